zic_nest_ctrl: RTL and testbench
================================

ZIC_NEST_CTRL -- requirements
Module: zic_nest_ctrl

Interface
REQ-001 SHALL have parameter NEST_DEPTH, default 4, meaning the maximum number of simultaneously active nested interrupts (2..8).
REQ-002 SHALL have port zic_clk  in  1  system clock; all state SHALL be updated on its rising edge.
REQ-003 SHALL have port zic_rst  in  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port interrupt_request_i  in  1  pending enabled interrupt flag from the ZIC.
REQ-005 SHALL have port highest_pending_lvl_pr_i  in  8  level-priority of the winning pending interrupt.
REQ-006 SHALL have port global_int_enable_i  in  1  core global interrupt enable (MIE).
REQ-007 SHALL have port zic_ack_read_valid_en_o  out  1  one-cycle acknowledge-read strobe to the ZIC MMR.
REQ-008 SHALL have port zic_ack_int_id_i  in  8  acknowledged interrupt ID, valid the cycle after the strobe.
REQ-009 SHALL have port core_irq_o  out  1  interrupt request to the core.
REQ-010 SHALL have port core_irq_id_o  out  8  ID presented with core_irq_o.
REQ-011 SHALL have port core_irq_taken_i  in  1  one-cycle pulse: the core entered the handler.
REQ-012 SHALL have port core_eoi_i  in  1  one-cycle pulse: the core finished the current handler.
REQ-013 SHALL have port zic_eoi_valid_o / zic_eoi_id_o  out  1/8  EOI strobe and ID to the ZIC MMR.
REQ-014 SHALL have port active_lvl_pr_o  out  8  level-priority of the top-of-stack entry; 0 when the stack is empty.
REQ-015 SHALL have port nest_depth_o  out  4  current stack occupancy.
REQ-016 SHALL have port nest_overflow_o / spurious_eoi_o  out  1/1  sticky error flags.

Function
REQ-017 SHALL implement the FSM states IDLE, ACK, CAPT and REQ.
REQ-018 IDLE->ACK SHALL occur when all of the following hold: interrupt_request_i=1; global_int_enable_i=1; highest_pending_lvl_pr_i > active_lvl_pr_o; nest_depth_o < NEST_DEPTH.
REQ-019 On the IDLE->ACK transition, the block SHALL latch highest_pending_lvl_pr_i as the pending level.
REQ-020 In ACK, zic_ack_read_valid_en_o SHALL be 1 for exactly one cycle, followed by ACK->CAPT.
REQ-021 In CAPT, the block SHALL register zic_ack_int_id_i into core_irq_id_o and move to REQ.
REQ-022 In REQ, core_irq_o SHALL stay 1 until core_irq_taken_i, even if interrupt_request_i or global_int_enable_i drops.
REQ-023 On core_irq_taken_i in REQ, the block SHALL push {ID, level}, increment the depth, update active_lvl_pr_o the next cycle, and go to IDLE.
REQ-024 core_irq_taken_i outside REQ SHALL be ignored.
REQ-025 When the IDLE qualifying condition holds except for depth == NEST_DEPTH, nest_overflow_o SHALL set and the request SHALL NOT be acknowledged.
REQ-026 core_eoi_i with depth > 0 SHALL, in any state, pulse zic_eoi_valid_o for one cycle with zic_eoi_id_o = top ID, pop, and restore active_lvl_pr_o to the new top level, or 0 if empty.
REQ-027 core_eoi_i with depth = 0 SHALL set spurious_eoi_o, produce no zic_eoi_valid_o, and leave state unchanged.
REQ-028 When core_irq_taken_i and core_eoi_i arrive in the same cycle, the block SHALL issue the EOI for the old top and overwrite the top slot with the new entry, leaving depth unchanged.
REQ-029 Level comparison SHALL be unsigned 8-bit; equal level SHALL NOT preempt.
REQ-030 Depth arithmetic SHALL never wrap: no push at NEST_DEPTH and no pop at 0.

Reset
REQ-031 With zic_rst=0, the FSM SHALL be in IDLE and every output and all stack entries SHALL be 0.
REQ-032 Reset mid-sequence SHALL discard any in-flight acknowledged ID without issuing an EOI.
REQ-033 Sticky flags SHALL clear only on reset.

Configuration
REQ-034 With macro ZIC_NEST_PREEMPT_EN defined, nesting up to NEST_DEPTH SHALL be supported as specified above.
REQ-035 With ZIC_NEST_PREEMPT_EN undefined, the effective depth SHALL be 1: IDLE->ACK only when depth = 0, and nest_overflow_o SHALL set on a qualifying request while depth = 1.

Verification
REQ-036 Scenario: pending lvl 0x20, MIE=1, ack ID 5, taken after 3 cycles -> strobe at cycle 1, core_irq_id_o=5 at cycle 3, active_lvl_pr_o=0x20, depth 1.
REQ-037 Scenario: lvl 0x20 active, new pending lvl 0x20 then 0x40 (ID 9) -> no ack for 0x20; ack for 0x40, depth 2; EOI -> zic_eoi_id_o=9, active 0x20.
REQ-038 Scenario: fill 4 nested levels 0x10..0x40, then pending 0x50 -> no strobe, nest_overflow_o=1, depth stays 4.
REQ-039 Scenario: EOI at depth 0 -> spurious_eoi_o=1, zic_eoi_valid_o stays 0.
REQ-040 Scenario: taken and EOI in the same cycle at depth 1 (top ID 3, new ID 7) -> EOI ID 3, depth 1, top ID 7.
REQ-041 Scenario: reset asserted in REQ -> core_irq_o=0 immediately, depth 0; no EOI after release.

Source files
------------

// File: rtl/zic_nest_ctrl.sv
// Nested-interrupt controller between the ZIC and the core: acknowledges, presents and stacks interrupts.
// Define ZIC_NEST_PREEMPT_EN for nesting up to NEST_DEPTH; otherwise the effective depth is 1.
module zic_nest_ctrl #(
  parameter int NEST_DEPTH = 4
) (
  input  logic       zic_clk,
  input  logic       zic_rst,
  input  logic       interrupt_request_i,
  input  logic [7:0] highest_pending_lvl_pr_i,
  input  logic       global_int_enable_i,
  output logic       zic_ack_read_valid_en_o,
  input  logic [7:0] zic_ack_int_id_i,
  output logic       core_irq_o,
  output logic [7:0] core_irq_id_o,
  input  logic       core_irq_taken_i,
  input  logic       core_eoi_i,
  output logic       zic_eoi_valid_o,
  output logic [7:0] zic_eoi_id_o,
  output logic [7:0] active_lvl_pr_o,
  output logic [3:0] nest_depth_o,
  output logic       nest_overflow_o,
  output logic       spurious_eoi_o,
  output logic [1:0] fsm_state
);

  localparam int IW = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;
`ifdef ZIC_NEST_PREEMPT_EN
  localparam logic [3:0] EFF_DEPTH = 4'(NEST_DEPTH);
`else
  localparam logic [3:0] EFF_DEPTH = 4'd1;
`endif

  typedef enum logic [1:0] {IDLE, ACK, CAPT, REQ} state_t;

  state_t          state, state_nxt;
  logic [7:0]      id_stk  [NEST_DEPTH];
  logic [7:0]      lvl_stk [NEST_DEPTH];
  logic [3:0]      depth;
  logic [7:0]      pend_lvl;
  logic [IW-1:0]   top_idx, push_idx;
  logic            qualify, do_ack, do_overflow;
  logic            push, pop, spurious;

  assign top_idx         = IW'(depth - 4'd1);
  assign push_idx        = IW'(depth);
  assign active_lvl_pr_o = (depth == 4'd0) ? 8'h00 : lvl_stk[top_idx];
  assign nest_depth_o    = depth;
  assign fsm_state       = state;

  // Equal level never preempts: strictly greater than the current top.
  assign qualify = interrupt_request_i && global_int_enable_i &&
                   (highest_pending_lvl_pr_i > active_lvl_pr_o);

  assign zic_ack_read_valid_en_o = (state == ACK);
  assign core_irq_o              = (state == REQ);

  assign push     = (state == REQ) && core_irq_taken_i;
  assign pop      = core_eoi_i && (depth != 4'd0);
  assign spurious = core_eoi_i && (depth == 4'd0);

  always_comb begin
    state_nxt   = state;
    do_ack      = 1'b0;
    do_overflow = 1'b0;
    case (state)
      IDLE: begin
        if (qualify) begin
          if (depth < EFF_DEPTH) begin
            do_ack    = 1'b1;
            state_nxt = ACK;
          end else begin
            do_overflow = 1'b1;
          end
        end
      end
      ACK:  state_nxt = CAPT;
      CAPT: state_nxt = REQ;
      REQ:  if (core_irq_taken_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge zic_clk or negedge zic_rst) begin
    if (!zic_rst) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge zic_clk or negedge zic_rst) begin
    if (!zic_rst) begin
      depth           <= 4'd0;
      pend_lvl        <= 8'h00;
      core_irq_id_o   <= 8'h00;
      zic_eoi_valid_o <= 1'b0;
      zic_eoi_id_o    <= 8'h00;
      nest_overflow_o <= 1'b0;
      spurious_eoi_o  <= 1'b0;
      for (int i = 0; i < NEST_DEPTH; i++) begin
        id_stk[i]  <= 8'h00;
        lvl_stk[i] <= 8'h00;
      end
    end else begin
      if (do_ack)        pend_lvl      <= highest_pending_lvl_pr_i;
      if (state == CAPT) core_irq_id_o <= zic_ack_int_id_i;

      zic_eoi_valid_o <= pop;
      zic_eoi_id_o    <= pop ? id_stk[top_idx] : 8'h00;

      // Simultaneous taken+EOI retires the old top and reuses its slot.
      if (push && pop) begin
        id_stk[top_idx]  <= core_irq_id_o;
        lvl_stk[top_idx] <= pend_lvl;
      end else if (push && (depth < EFF_DEPTH)) begin
        id_stk[push_idx]  <= core_irq_id_o;
        lvl_stk[push_idx] <= pend_lvl;
        depth             <= depth + 4'd1;
      end else if (pop) begin
        depth <= depth - 4'd1;
      end

      if (do_overflow) nest_overflow_o <= 1'b1;
      if (spurious)    spurious_eoi_o  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_zic_nest_ctrl.sv
// Directed bench for zic_nest_ctrl; a negedge monitor checks ack strobes, core requests and EOIs against expected queues.
module tb_zic_nest_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       irq = 1'b0;
  logic [7:0] hp = 8'h00;
  logic       mie = 1'b0;
  logic       ack;
  logic [7:0] ack_id = 8'h00;
  logic       core_irq;
  logic [7:0] core_irq_id;
  logic       taken = 1'b0;
  logic       eoi = 1'b0;
  logic       eoi_valid;
  logic [7:0] eoi_id;
  logic [7:0] active_lvl;
  logic [3:0] depth;
  logic       overflow;
  logic       spurious;
  logic [1:0] fsm_state;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_ack_q[$];
  logic [7:0] exp_irq_q[$];
  logic [7:0] exp_eoi_q[$];
  logic       prev_irq = 1'b0;

  always #5 clk = ~clk;

  zic_nest_ctrl #(.NEST_DEPTH(4)) dut (
    .zic_clk                  (clk),
    .zic_rst                  (rst_n),
    .interrupt_request_i      (irq),
    .highest_pending_lvl_pr_i (hp),
    .global_int_enable_i      (mie),
    .zic_ack_read_valid_en_o  (ack),
    .zic_ack_int_id_i         (ack_id),
    .core_irq_o               (core_irq),
    .core_irq_id_o            (core_irq_id),
    .core_irq_taken_i         (taken),
    .core_eoi_i               (eoi),
    .zic_eoi_valid_o          (eoi_valid),
    .zic_eoi_id_o             (eoi_id),
    .active_lvl_pr_o          (active_lvl),
    .nest_depth_o             (depth),
    .nest_overflow_o          (overflow),
    .spurious_eoi_o           (spurious),
    .fsm_state                (fsm_state)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every DUT output event must be matched by a queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ack) begin
        checks++;
        if (exp_ack_q.size() == 0) begin
          errors++;
          $display("FAIL ack_strobe unexpected actual=1 expected=0");
        end else begin
          void'(exp_ack_q.pop_front());
        end
      end
      if (core_irq && !prev_irq) begin
        if (exp_irq_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL core_irq unexpected id actual=%0h expected=none", core_irq_id);
        end else begin
          chk("core_irq_id", core_irq_id, exp_irq_q.pop_front());
        end
      end
      if (eoi_valid) begin
        if (exp_eoi_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL zic_eoi unexpected id actual=%0h expected=none", eoi_id);
        end else begin
          chk("zic_eoi_id", eoi_id, exp_eoi_q.pop_front());
        end
      end
    end
    prev_irq = core_irq;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full acknowledge/present/take sequence; optionally retire the old top in the same cycle as taken.
  task automatic service(input logic [7:0] lvl, input logic [7:0] id, input int wait_c,
                         input bit with_eoi, input logic [7:0] old_id);
    exp_ack_q.push_back(lvl);
    exp_irq_q.push_back(id);
    irq = 1'b1;
    mie = 1'b1;
    hp  = lvl;
    step();
    irq = 1'b0;
    step();
    ack_id = id;
    step();
    ack_id = 8'h00;
    chk("irq_id_in_req", core_irq_id, id);
    repeat (wait_c) step();
    taken = 1'b1;
    if (with_eoi) begin
      eoi = 1'b1;
      exp_eoi_q.push_back(old_id);
    end
    step();
    taken = 1'b0;
    eoi   = 1'b0;
  endtask

  task automatic do_eoi(input bit exp_valid, input logic [7:0] id);
    eoi = 1'b1;
    if (exp_valid) exp_eoi_q.push_back(id);
    step();
    eoi = 1'b0;
  endtask

  // Present a request that must not be acknowledged.
  task automatic hold(input logic [7:0] lvl, input logic en, input int cycles);
    irq = 1'b1;
    mie = en;
    hp  = lvl;
    repeat (cycles) step();
    irq = 1'b0;
    hp  = 8'h00;
    step();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_core_irq", {7'd0, core_irq}, 8'h00);
    chk("rst_irq_id", core_irq_id, 8'h00);
    chk("rst_depth", {4'd0, depth}, 8'h00);
    chk("rst_active", active_lvl, 8'h00);
    chk("rst_flags", {6'd0, overflow, spurious}, 8'h00);
    chk("rst_state", {6'd0, fsm_state}, 8'h00);
    rst_n = 1'b1;
    step();

    service(8'h20, 8'h05, 3, 1'b0, 8'h00);
    chk("s1_active", active_lvl, 8'h20);
    chk("s1_depth", {4'd0, depth}, 8'h01);

`ifdef ZIC_NEST_PREEMPT_EN
    hold(8'h20, 1'b1, 3);
    chk("equal_lvl_depth", {4'd0, depth}, 8'h01);
    service(8'h40, 8'h09, 1, 1'b0, 8'h00);
    chk("nest_depth2", {4'd0, depth}, 8'h02);
    chk("nest_active40", active_lvl, 8'h40);
    do_eoi(1'b1, 8'h09);
    chk("eoi_restore20", active_lvl, 8'h20);
    chk("eoi_depth1", {4'd0, depth}, 8'h01);
    do_eoi(1'b1, 8'h05);
    chk("eoi_depth0", {4'd0, depth}, 8'h00);

    for (int i = 1; i <= 4; i++) service(8'(i * 16), 8'(i), 1, 1'b0, 8'h00);
    chk("fill_depth4", {4'd0, depth}, 8'h04);
    chk("fill_active40", active_lvl, 8'h40);
    chk("pre_overflow", {7'd0, overflow}, 8'h00);
    hold(8'h50, 1'b1, 3);
    chk("overflow_set", {7'd0, overflow}, 8'h01);
    chk("overflow_depth", {4'd0, depth}, 8'h04);
    for (int i = 4; i >= 1; i--) begin
      do_eoi(1'b1, 8'(i));
      chk("unwind_active", active_lvl, 8'((i - 1) * 16));
    end
    chk("overflow_sticky", {7'd0, overflow}, 8'h01);

    service(8'h30, 8'h03, 1, 1'b0, 8'h00);
    service(8'h50, 8'h07, 1, 1'b1, 8'h03);
    chk("swap_depth", {4'd0, depth}, 8'h01);
    chk("swap_active", active_lvl, 8'h50);
    do_eoi(1'b1, 8'h07);
    chk("swap_final_depth", {4'd0, depth}, 8'h00);
`else
    chk("pre_overflow", {7'd0, overflow}, 8'h00);
    hold(8'h40, 1'b1, 3);
    chk("overflow_set", {7'd0, overflow}, 8'h01);
    chk("overflow_depth", {4'd0, depth}, 8'h01);
    chk("overflow_active", active_lvl, 8'h20);
    do_eoi(1'b1, 8'h05);
    chk("eoi_depth0", {4'd0, depth}, 8'h00);
    chk("eoi_active0", active_lvl, 8'h00);
    chk("overflow_sticky", {7'd0, overflow}, 8'h01);
`endif

    chk("pre_spurious", {7'd0, spurious}, 8'h00);
    do_eoi(1'b0, 8'h00);
    chk("spurious_set", {7'd0, spurious}, 8'h01);
    chk("spurious_depth", {4'd0, depth}, 8'h00);

    hold(8'h70, 1'b0, 3);
    chk("mie_off_depth", {4'd0, depth}, 8'h00);
    hold(8'h00, 1'b1, 3);
    chk("lvl0_depth", {4'd0, depth}, 8'h00);

    taken = 1'b1;
    step();
    taken = 1'b0;
    chk("stray_taken_depth", {4'd0, depth}, 8'h00);
    chk("stray_taken_state", {6'd0, fsm_state}, 8'h00);

    // Reset while the core request is outstanding.
    exp_ack_q.push_back(8'h60);
    exp_irq_q.push_back(8'h0b);
    irq = 1'b1;
    mie = 1'b1;
    hp  = 8'h60;
    step();
    irq = 1'b0;
    step();
    ack_id = 8'h0b;
    step();
    ack_id = 8'h00;
    step();
    chk("req_before_rst", {7'd0, core_irq}, 8'h01);
    rst_n = 1'b0;
    #1;
    chk("rst_req_irq", {7'd0, core_irq}, 8'h00);
    chk("rst_req_depth", {4'd0, depth}, 8'h00);
    chk("rst_req_id", core_irq_id, 8'h00);
    step();
    rst_n = 1'b1;
    repeat (4) step();
    chk("rst_flags_clear", {6'd0, overflow, spurious}, 8'h00);
    chk("rst_state_idle", {6'd0, fsm_state}, 8'h00);

    repeat (3) step();
    chk("ack_q_empty", 8'(exp_ack_q.size()), 8'h00);
    chk("irq_q_empty", 8'(exp_irq_q.size()), 8'h00);
    chk("eoi_q_empty", 8'(exp_eoi_q.size()), 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
